// File: rtl/uart_fifo_core.sv
// uart_fifo_core: buffered UART transmitter plus 16x-oversampled receiver sharing one
// programmable tick divider. Frame format (parity, stop bits) is latched at each frame start.
module uart_fifo_core #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           baud_div,
    input  logic                  parity_en,
    input  logic                  odd_r_even_parity,
    input  logic                  stop2,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx,
    output logic                  busy,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_error,
    output logic                  framing_error
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned BitW = $clog2(DATA_WIDTH);
    localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);
    localparam logic [BitW-1:0] BitOne = BitW'(1);
    localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

    typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;

    logic [15:0] div_cnt_q, div_cnt_d;
    logic        tick;

    logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PtrW:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  fifo_empty, fifo_full, fifo_wr, fifo_rd;
    logic [DATA_WIDTH-1:0] fifo_rd_data;

    tx_state_e             tx_state_q, tx_state_d;
    logic [3:0]            tx_tick_q, tx_tick_d;
    logic [BitW-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    logic                  tx_par_q, tx_par_d, tx_par_en_q, tx_par_en_d, tx_stop2_q, tx_stop2_d;
    logic                  tx_tick_end, tx_load;

    logic                  rx_s1_q, rx_s2_q, rx_s3_q;
    logic                  rx_fall;
    rx_state_e             rx_state_q, rx_state_d;
    logic [3:0]            rx_tick_q, rx_tick_d;
    logic [BitW-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic                  rx_par_en_q, rx_par_en_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d;
    logic                  rx_valid_q, rx_valid_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                  rx_tick_end;

    // Tick divider and TX FIFO bookkeeping.
    always_comb begin
        tick         = (div_cnt_q >= baud_div);
        div_cnt_d    = tick ? 16'd0 : div_cnt_q + 16'd1;
        fifo_empty   = (wr_ptr_q == rd_ptr_q);
        fifo_full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                       (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
        fifo_wr      = tx_valid && !fifo_full;
        fifo_rd_data = fifo_mem_q[rd_ptr_q[PtrW-1:0]];
        wr_ptr_d     = fifo_wr ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d     = fifo_rd ? rd_ptr_q + PtrOne : rd_ptr_q;
        tx_ready     = !fifo_full;
        busy         = !fifo_empty || (tx_state_q != TxIdle);
    end

    // TX next state: every state spans 16 ticks; STOP reloads directly when more data waits.
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_tick_d   = tx_tick_q;
        tx_bit_d    = tx_bit_q;
        tx_shift_d  = tx_shift_q;
        tx_par_d    = tx_par_q;
        tx_par_en_d = tx_par_en_q;
        tx_stop2_d  = tx_stop2_q;
        tx_load     = 1'b0;
        fifo_rd     = 1'b0;
        tx_tick_end = tick && (tx_tick_q == 4'd15);
        if (tick && (tx_state_q != TxIdle)) tx_tick_d = tx_tick_q + 4'd1;
        unique case (tx_state_q)
            TxIdle:  tx_load = tick && !fifo_empty;
            TxStart: if (tx_tick_end) begin
                tx_state_d = TxData;
                tx_bit_d   = '0;
            end
            TxData: if (tx_tick_end) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + BitOne;
                if (tx_bit_q == LastBit) begin
                    tx_state_d = tx_par_en_q ? TxParity : TxStop;
                    tx_bit_d   = '0;
                end
            end
            TxParity: if (tx_tick_end) tx_state_d = TxStop;
            TxStop: if (tx_tick_end) begin
                // tx_bit_q doubles as the stop-bit index
                if (tx_stop2_q && (tx_bit_q == '0)) tx_bit_d = BitOne;
                else if (!fifo_empty) tx_load = 1'b1;
                else tx_state_d = TxIdle;
            end
            default: tx_state_d = TxIdle;
        endcase
        if (tx_load) begin
            fifo_rd     = 1'b1;
            tx_state_d  = TxStart;
            tx_tick_d   = '0;
            tx_bit_d    = '0;
            tx_shift_d  = fifo_rd_data;
            tx_par_d    = ^fifo_rd_data ^ odd_r_even_parity;
            tx_par_en_d = parity_en;
            tx_stop2_d  = stop2;
        end
    end

    // Serial output decoded from TX state.
    always_comb begin
        tx = 1'b1;
        unique case (tx_state_q)
            TxStart:  tx = 1'b0;
            TxData:   tx = tx_shift_q[0];
            TxParity: tx = tx_par_q;
            default:  tx = 1'b1;
        endcase
    end

    // RX next state: START checks mid-bit after 8 ticks, later samples every 16 ticks.
    always_comb begin
        rx_fall     = rx_s3_q && !rx_s2_q;
        rx_state_d  = rx_state_q;
        rx_tick_d   = rx_tick_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_par_en_d = rx_par_en_q;
        rx_odd_d    = rx_odd_q;
        rx_perr_d   = rx_perr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        rx_tick_end = tick && (rx_tick_q == 4'd15);
        if (tick && (rx_state_q != RxIdle)) rx_tick_d = rx_tick_q + 4'd1;
        unique case (rx_state_q)
            RxIdle: if (rx_fall) begin
                rx_state_d  = RxStart;
                rx_tick_d   = '0;
                rx_perr_d   = 1'b0;
                rx_par_en_d = parity_en;
                rx_odd_d    = odd_r_even_parity;
            end
            RxStart: if (tick && (rx_tick_q == 4'd7)) begin
                if (rx_s2_q) begin
                    rx_state_d = RxIdle;
                end else begin
                    rx_state_d = RxData;
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                end
            end
            RxData: if (rx_tick_end) begin
                rx_shift_d = {rx_s2_q, rx_shift_q[DATA_WIDTH-1:1]};
                rx_bit_d   = rx_bit_q + BitOne;
                if (rx_bit_q == LastBit) rx_state_d = rx_par_en_q ? RxParity : RxStop;
            end
            RxParity: if (rx_tick_end) begin
                rx_perr_d  = ((^rx_shift_q) ^ rx_s2_q) != rx_odd_q;
                rx_state_d = RxStop;
            end
            RxStop: if (rx_tick_end) begin
                rx_valid_d = 1'b1;
                rx_data_d  = rx_shift_q;
                perr_d     = rx_perr_q;
                ferr_d     = !rx_s2_q;
                rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
        rx_data       = rx_data_q;
        rx_valid      = rx_valid_q;
        parity_error  = perr_q;
        framing_error = ferr_q;
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem_q[wr_ptr_q[PtrW-1:0]] <= tx_data;
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tx_state_q  <= TxIdle;
            tx_tick_q   <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_par_q    <= 1'b0;
            tx_par_en_q <= 1'b0;
            tx_stop2_q  <= 1'b0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            rx_state_q  <= RxIdle;
            rx_tick_q   <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_par_en_q <= 1'b0;
            rx_odd_q    <= 1'b0;
            rx_perr_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tx_state_q  <= tx_state_d;
            tx_tick_q   <= tx_tick_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_par_q    <= tx_par_d;
            tx_par_en_q <= tx_par_en_d;
            tx_stop2_q  <= tx_stop2_d;
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            rx_state_q  <= rx_state_d;
            rx_tick_q   <= rx_tick_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_par_en_q <= rx_par_en_d;
            rx_odd_q    <= rx_odd_d;
            rx_perr_q   <= rx_perr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end
endmodule
